mux_n_1_rr: RTL and testbench

Parametrised N:1 multiplexer with a registered output, the sequential successor to the team's 4:1 combinational mux. Each of CHANNELS input lanes offers WIDTH-bit data with a valid/ready handshake. One lane is granted per transfer, either by an explicit select or by round-robin arbitration. The single-entry output register feeds a downstream valid/ready consumer. It sits between multiple producers and one shared datapath consumer.

---
 rtl/mux_n_1_rr_if.sv | 39 +++
 rtl/mux_n_1_rr.sv | 103 ++++++++++
 tb/tb_mux_n_1_rr.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mux_n_1_rr_if.sv
// Bus bundle for mux_n_1_rr: per-lane inputs, select controls and the registered output.
// MUX_N_PARITY_EN adds out_parity to the bundle.
interface mux_n_1_rr_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_ch;
  logic                      out_valid;
  logic                      out_ready;
`ifdef MUX_N_PARITY_EN
  logic                      out_parity;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid, out_parity
  );
  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid, out_parity
  );
`else
  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );
  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
`endif
endinterface

// File: rtl/mux_n_1_rr.sv
// N:1 mux (fixed select or round-robin) into a single-entry output register; MUX_N_PARITY_EN adds out_parity.
// Latency 1 cycle, 1 word/cycle; in_ready drops whenever the held word is not being popped.
module mux_n_1_rr #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input logic        clk,
  input logic        rst,
  mux_n_1_rr_if.slave bus
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [WIDTH-1:0]    data_q;
  logic [SEL_W-1:0]    ch_q;
  logic                valid_q;
  logic [SEL_W-1:0]    ptr;
  logic                can_load;
  logic                grant_vld;
  logic [SEL_W-1:0]    grant;
  logic [WIDTH-1:0]    grant_data;
  logic                grant_in_valid;
  logic [CHANNELS-1:0] ready;
  logic                xfer;
  logic [SEL_W-1:0]    ptr_next;
`ifdef MUX_N_PARITY_EN
  logic                parity_q;
`endif

  assign can_load = !valid_q | bus.out_ready;

  // Round-robin picks the valid lane with the smallest distance above ptr (mod CHANNELS).
  always_comb begin
    int best_d;
    int d;
    grant_vld = 1'b0;
    grant     = '0;
    best_d    = CHANNELS;
    d         = 0;
    if (!bus.mode) begin
      if (32'(bus.sel) < CHANNELS) begin
        grant_vld = 1'b1;
        grant     = bus.sel;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        d = k - int'(ptr);
        if (d < 0) d = d + CHANNELS;
        if (bus.in_valid[k] && d < best_d) begin
          best_d    = d;
          grant_vld = 1'b1;
          grant     = SEL_W'(k);
        end
      end
    end
  end

  always_comb begin
    grant_data     = '0;
    grant_in_valid = 1'b0;
    ready          = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (grant_vld && grant == SEL_W'(k)) begin
        grant_data     = bus.in_data[k*WIDTH +: WIDTH];
        grant_in_valid = bus.in_valid[k];
        ready[k]       = can_load & !rst;
      end
    end
  end

  assign xfer     = grant_vld & can_load & !rst & grant_in_valid;
  assign ptr_next = (grant == SEL_W'(CHANNELS - 1)) ? '0 : grant + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      ptr     <= '0;
    end else begin
      if (xfer) begin
        data_q  <= grant_data;
        ch_q    <= grant;
        valid_q <= 1'b1;
        if (bus.mode) ptr <= ptr_next;
      end else if (valid_q && bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef MUX_N_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)       parity_q <= 1'b0;
    else if (xfer) parity_q <= ^grant_data;
  end
  assign bus.out_parity = parity_q;
`endif

  assign bus.in_ready  = ready;
  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_mux_n_1_rr.sv
// Bench for mux_n_1_rr: a 4-lane and a 3-lane instance against a queue-free scan model.
module tb_mux_n_1_rr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_n_1_rr_if #(.WIDTH(8), .CHANNELS(4)) b4();
  mux_n_1_rr_if #(.WIDTH(8), .CHANNELS(3)) b3();

  mux_n_1_rr #(.WIDTH(8), .CHANNELS(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
  mux_n_1_rr #(.WIDTH(8), .CHANNELS(3)) u_dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

  int checks = 0;
  int errors = 0;

  // Reference state per instance: [0] = 4-lane, [1] = 3-lane
  logic       m_vld [2] = '{1'b0, 1'b0};
  logic [7:0] m_dat [2] = '{8'h0, 8'h0};
  int         m_ch  [2] = '{0, 0};
  int         m_ptr [2] = '{0, 0};
  logic       m_par [2] = '{1'b0, 1'b0};

  function automatic int ref_grant(int n, logic md, int s, logic [15:0] v, int p);
    if (!md) return (s < n) ? s : -1;
    for (int i = 0; i < n; i++) begin
      if (v[(p + i) % n]) return (p + i) % n;
    end
    return -1;
  endfunction

  function automatic logic [15:0] exp_ready(int i, int n, logic md, int s, logic [15:0] v, logic ordy);
    int g;
    g = ref_grant(n, md, s, v, m_ptr[i]);
    if (rst || g < 0 || !(!m_vld[i] || ordy)) return 16'h0;
    return 16'h1 << g;
  endfunction

  task automatic model_step(input int i, input int n, input logic md, input int s,
                            input logic [15:0] v, input logic [127:0] d, input logic ordy);
    int g;
    g = ref_grant(n, md, s, v, m_ptr[i]);
    if (rst) begin
      m_vld[i] = 1'b0; m_dat[i] = 8'h0; m_ch[i] = 0; m_ptr[i] = 0; m_par[i] = 1'b0;
    end else if (g >= 0 && (!m_vld[i] || ordy) && v[g]) begin
      m_vld[i] = 1'b1;
      m_dat[i] = d[g*8 +: 8];
      m_ch[i]  = g;
      m_par[i] = ^d[g*8 +: 8];
      if (md) m_ptr[i] = (g + 1) % n;
    end else if (m_vld[i] && ordy) begin
      m_vld[i] = 1'b0;
    end
  endtask

  task automatic tick();
    model_step(0, 4, b4.mode, int'(b4.sel), 16'(b4.in_valid), 128'(b4.in_data), b4.out_ready);
    model_step(1, 3, b3.mode, int'(b3.sel), 16'(b3.in_valid), 128'(b3.in_data), b3.out_ready);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b4.in_data = 32'h44332211; b4.in_valid = 4'hF; b4.mode = 1'b0; b4.sel = 2'd0; b4.out_ready = 1'b1;
    b3.in_data = 24'h0; b3.in_valid = 3'h0; b3.mode = 1'b0; b3.sel = 2'd0; b3.out_ready = 1'b1;
    #1;
    checks++; if (b4.in_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready_pre: got %b want 0000", b4.in_ready); end
    tick();
    tick();
    checks++; if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", b4.out_valid); end
    checks++; if (b4.out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", b4.out_data); end
    checks++; if (b4.out_ch !== 2'd0) begin errors++; $display("FAIL reset_ch: got %0d want 0", b4.out_ch); end
    checks++; if (b4.in_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", b4.in_ready); end
    rst = 1'b0;
    #1;
    checks++; if (b4.in_ready !== 4'b0001) begin errors++; $display("FAIL reset_release_ready: got %b want 0001", b4.in_ready); end
  endtask

  task automatic test_fixed_select();
    b4.in_data = {8'h44, 8'h33, 8'h22, 8'h11}; b4.in_valid = 4'hF; b4.mode = 1'b0; b4.sel = 2'd2; b4.out_ready = 1'b1;
    #1;
    checks++; if (b4.in_ready !== 4'b0100) begin errors++; $display("FAIL fixed_ready: got %b want 0100", b4.in_ready); end
    tick();
    checks++; if (b4.out_data !== 8'h33 || b4.out_ch !== 2'd2 || b4.out_valid !== 1'b1) begin
      errors++; $display("FAIL fixed_sel2: got data=%h ch=%0d v=%b want data=33 ch=2 v=1", b4.out_data, b4.out_ch, b4.out_valid); end
    b4.sel = 2'd3;
    tick();
    checks++; if (b4.out_data !== 8'h44 || b4.out_ch !== 2'd3) begin
      errors++; $display("FAIL fixed_sel3: got data=%h ch=%0d want data=44 ch=3", b4.out_data, b4.out_ch); end
  endtask

  task automatic test_rr_fairness();
    b4.mode = 1'b1; b4.in_valid = 4'hF; b4.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b4.in_data = $urandom;
      tick();
      checks++; if (int'(b4.out_ch) != i % 4 || b4.out_valid !== 1'b1 || b4.out_data !== m_dat[0]) begin
        errors++; $display("FAIL rr_fair[%0d]: got ch=%0d v=%b data=%h want ch=%0d v=1 data=%h",
                           i, b4.out_ch, b4.out_valid, b4.out_data, i % 4, m_dat[0]); end
    end
  endtask

  task automatic test_rr_skip_wrap();
    int exp_seq [3] = '{0, 2, 0};
    // One more grant on all-valid leaves the pointer at 3
    tick();
    checks++; if (b4.out_ch !== 2'd2) begin errors++; $display("FAIL rr_prewrap: got ch=%0d want 2", b4.out_ch); end
    b4.in_valid = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (int'(b4.out_ch) != exp_seq[i] || b4.out_valid !== 1'b1) begin
        errors++; $display("FAIL rr_skip[%0d]: got ch=%0d v=%b want ch=%0d v=1", i, b4.out_ch, b4.out_valid, exp_seq[i]); end
    end
  endtask

  task automatic test_backpressure();
    b4.mode = 1'b0; b4.sel = 2'd1; b4.in_valid = 4'hF; b4.out_ready = 1'b1;
    b4.in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    tick();
    b4.out_ready = 1'b0;
    b4.in_data = {8'h44, 8'h33, 8'h5A, 8'h11};
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (b4.in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, b4.in_ready); end
      tick();
      checks++; if (b4.out_data !== 8'h22 || b4.out_ch !== 2'd1 || b4.out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold[%0d]: got data=%h ch=%0d v=%b want data=22 ch=1 v=1", i, b4.out_data, b4.out_ch, b4.out_valid); end
    end
    b4.out_ready = 1'b1;
    #1;
    checks++; if (b4.in_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready: got %b want 0010", b4.in_ready); end
    tick();
    checks++; if (b4.out_data !== 8'h5A || b4.out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_pop_push: got data=%h v=%b want data=5a v=1", b4.out_data, b4.out_valid); end
    b4.in_valid = 4'h0;
    tick();
    checks++; if (b4.out_valid !== 1'b0 || b4.out_data !== 8'h5A || b4.out_ch !== 2'd1) begin
      errors++; $display("FAIL pop_only: got data=%h ch=%0d v=%b want data=5a ch=1 v=0", b4.out_data, b4.out_ch, b4.out_valid); end
  endtask

  task automatic test_out_of_range();
    int exp_seq [4] = '{0, 1, 2, 0};
    b3.in_data = {8'h33, 8'h22, 8'h11}; b3.in_valid = 3'b111; b3.mode = 1'b0; b3.sel = 2'd3; b3.out_ready = 1'b1;
    #1;
    checks++; if (b3.in_ready !== 3'b000) begin errors++; $display("FAIL oor_ready: got %b want 000", b3.in_ready); end
    tick();
    checks++; if (b3.out_valid !== 1'b0) begin errors++; $display("FAIL oor_noload: got v=%b want 0", b3.out_valid); end
    b3.sel = 2'd2;
    #1;
    checks++; if (b3.in_ready !== 3'b100) begin errors++; $display("FAIL c3_sel2_ready: got %b want 100", b3.in_ready); end
    tick();
    checks++; if (b3.out_ch !== 2'd2 || b3.out_data !== 8'h33) begin
      errors++; $display("FAIL c3_sel2: got ch=%0d data=%h want ch=2 data=33", b3.out_ch, b3.out_data); end
    b3.mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (int'(b3.out_ch) != exp_seq[i]) begin
        errors++; $display("FAIL c3_rr_wrap[%0d]: got ch=%0d want %0d", i, b3.out_ch, exp_seq[i]); end
    end
    b3.in_valid = 3'b000;
    tick();
  endtask

  task automatic test_parity();
    b4.mode = 1'b0; b4.sel = 2'd0; b4.in_valid = 4'b0001; b4.out_ready = 1'b1;
    b4.in_data = 32'h0000_0007;
    tick();
    checks++; if (b4.out_data !== 8'h07) begin errors++; $display("FAIL par_load07: got %h want 07", b4.out_data); end
`ifdef MUX_N_PARITY_EN
    checks++; if (b4.out_parity !== 1'b1) begin errors++; $display("FAIL parity_07: got %b want 1", b4.out_parity); end
`endif
    b4.in_data = 32'h0000_0003;
    tick();
    checks++; if (b4.out_data !== 8'h03) begin errors++; $display("FAIL par_load03: got %h want 03", b4.out_data); end
`ifdef MUX_N_PARITY_EN
    checks++; if (b4.out_parity !== 1'b0) begin errors++; $display("FAIL parity_03: got %b want 0", b4.out_parity); end
`endif
  endtask

  task automatic test_random();
    logic [15:0] er;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst          = ($urandom_range(0, 59) == 0);
      b4.mode      = 1'($urandom);
      b4.sel       = 2'($urandom);
      b4.in_valid  = 4'($urandom);
      b4.in_data   = $urandom;
      b4.out_ready = ($urandom_range(0, 3) != 0);
      b3.mode      = 1'($urandom);
      b3.sel       = 2'($urandom);
      b3.in_valid  = 3'($urandom);
      b3.in_data   = 24'($urandom);
      b3.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      er = exp_ready(0, 4, b4.mode, int'(b4.sel), 16'(b4.in_valid), b4.out_ready);
      checks++; if (16'(b4.in_ready) !== er) begin errors++; $display("FAIL rand4_ready[%0d]: got %h want %h", cyc, b4.in_ready, er); end
      er = exp_ready(1, 3, b3.mode, int'(b3.sel), 16'(b3.in_valid), b3.out_ready);
      checks++; if (16'(b3.in_ready) !== er) begin errors++; $display("FAIL rand3_ready[%0d]: got %h want %h", cyc, b3.in_ready, er); end
      tick();
      checks++; if (b4.out_valid !== m_vld[0] || b4.out_data !== m_dat[0] || int'(b4.out_ch) != m_ch[0]) begin
        errors++; $display("FAIL rand4_out[%0d]: got v=%b d=%h ch=%0d want v=%b d=%h ch=%0d",
                           cyc, b4.out_valid, b4.out_data, b4.out_ch, m_vld[0], m_dat[0], m_ch[0]); end
      checks++; if (b3.out_valid !== m_vld[1] || b3.out_data !== m_dat[1] || int'(b3.out_ch) != m_ch[1]) begin
        errors++; $display("FAIL rand3_out[%0d]: got v=%b d=%h ch=%0d want v=%b d=%h ch=%0d",
                           cyc, b3.out_valid, b3.out_data, b3.out_ch, m_vld[1], m_dat[1], m_ch[1]); end
`ifdef MUX_N_PARITY_EN
      checks++; if (b4.out_parity !== m_par[0]) begin errors++; $display("FAIL rand4_parity[%0d]: got %b want %b", cyc, b4.out_parity, m_par[0]); end
`endif
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fixed_select();
    test_rr_fairness();
    test_rr_skip_wrap();
    test_backpressure();
    test_out_of_range();
    test_parity();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
